// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants: modulus, widths, butterfly mode codes and the
// 256-entry zeta table (Montgomery domain, reduced to [0, Q-1]).
package dilithium_pkg;

  localparam int Q       = 8380417;
  localparam int COEFF_W = 23;
  localparam int ADDR_W  = 8;

  localparam logic [2:0] FORWARD_NTT_MODE = 3'd0;
  localparam logic [2:0] INVERSE_NTT_MODE = 3'd1;
  localparam logic [2:0] MULT_MODE        = 3'd2;
  localparam logic [2:0] ADD_MODE         = 3'd3;
  localparam logic [2:0] SUB_MODE         = 3'd4;

  // Negative reference zetas are stored as Q - |z| so every entry is in [0, Q-1].
  localparam int ZETA_TABLE [256] = '{
    0,           25847,       Q-2608894,   Q-518909,    237124,      Q-777960,    Q-876248,    466468,
    1826347,     2353451,     Q-359251,    Q-2091905,   3119733,     Q-2884855,   3111497,     2680103,
    2725464,     1024112,     Q-1079900,   3585928,     Q-549488,    Q-1119584,   2619752,     Q-2108549,
    Q-2118186,   Q-3859737,   Q-1399561,   Q-3277672,   1757237,     Q-19422,     4010497,     280005,
    2706023,     95776,       3077325,     3530437,     Q-1661693,   Q-3592148,   Q-2537516,   3915439,
    Q-3861115,   Q-3043716,   3574422,     Q-2867647,   3539968,     Q-300467,    2348700,     Q-539299,
    Q-1699267,   Q-1643818,   3505694,     Q-3821735,   3507263,     Q-2140649,   Q-1600420,   3699596,
    811944,      531354,      954230,      3881043,     3900724,     Q-2556880,   2071892,     Q-2797779,
    Q-3930395,   Q-1528703,   Q-3677745,   Q-3041255,   Q-1452451,   3475950,     2176455,     Q-1585221,
    Q-1257611,   1939314,     Q-4083598,   Q-1000202,   Q-3190144,   Q-3157330,   Q-3632928,   126922,
    3412210,     Q-983419,    2147896,     2715295,     Q-2967645,   Q-3693493,   Q-411027,    Q-2477047,
    Q-671102,    Q-1228525,   Q-22981,     Q-1308169,   Q-381987,    1349076,     1852771,     Q-1430430,
    Q-3343383,   264944,      508951,      3097992,     44288,       Q-1100098,   904516,      3958618,
    Q-3724342,   Q-8578,      1653064,     Q-3249728,   2389356,     Q-210977,    759969,      Q-1316856,
    189548,      Q-3553272,   3159746,     Q-1851402,   Q-2409325,   Q-177440,    1315589,     1341330,
    1285669,     Q-1584928,   Q-812732,    Q-1439742,   Q-3019102,   Q-3881060,   Q-3628969,   3839961,
    2091667,     3407706,     2316500,     3817976,     Q-3342478,   2244091,     Q-2446433,   Q-3562462,
    266997,      2434439,     Q-1235728,   3513181,     Q-3520352,   Q-3759364,   Q-1197226,   Q-3193378,
    900702,      1859098,     909542,      819034,      495491,      Q-1613174,   Q-43260,     Q-522500,
    Q-655327,    Q-3122442,   2031748,     3207046,     Q-3556995,   Q-525098,    Q-768622,    Q-3595838,
    342297,      286988,      Q-2437823,   4108315,     3437287,     Q-3342277,   1735879,     203044,
    2842341,     2691481,     Q-2590150,   1265009,     4055324,     1247620,     2486353,     1595974,
    Q-3767016,   1250494,     2635921,     Q-3548272,   Q-2994039,   1869119,     1903435,     Q-1050970,
    Q-1333058,   1237275,     Q-3318210,   Q-1430225,   Q-451100,    1312455,     3306115,     Q-1962642,
    Q-1279661,   1917081,     Q-2546312,   Q-1374803,   1500165,     777191,      2235880,     3406031,
    Q-542412,    Q-2831860,   Q-1671176,   Q-1846953,   Q-2584293,   Q-3724270,   594136,      Q-3776993,
    Q-2013608,   2432395,     2454455,     Q-164721,    1957272,     3369112,     185531,      Q-1207385,
    Q-3183426,   162844,      1616392,     3014001,     810149,      1652634,     Q-3694233,   Q-1799107,
    Q-3038916,   3523897,     3866901,     269760,      2213111,     Q-975884,    1717735,     472078,
    Q-426683,    1723600,     Q-1803090,   1910376,     Q-1667432,   Q-1104333,   Q-260646,    Q-3833893,
    Q-2939036,   Q-2235985,   Q-420899,    Q-2286327,   183443,      Q-976891,    1612842,     Q-3545687,
    Q-554416,    3919660,     Q-48306,     Q-1362209,   3937738,     1400424,     Q-846154,    1976782
  };

endpackage

// File: rtl/twiddle_rom_server_if.sv
// Twiddle address/value bus between address generator, ROM server and butterflies.
// master drives addresses and consumes twiddles; slave is the ROM server.
interface twiddle_rom_server_if;
  import dilithium_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [2:0]          in_mode;
  logic [ADDR_W-1:0]   in_addr1;
  logic [ADDR_W-1:0]   in_addr2;
  logic [ADDR_W-1:0]   in_addr3;
  logic [ADDR_W-1:0]   in_addr4;
  logic                out_valid;
  logic                out_ready;
  logic [COEFF_W-1:0]  out_tw1;
  logic [COEFF_W-1:0]  out_tw2;
  logic [COEFF_W-1:0]  out_tw3;
  logic [COEFF_W-1:0]  out_tw4;

  modport master (
    output in_valid, in_mode, in_addr1, in_addr2, in_addr3, in_addr4, out_ready,
    input  in_ready, out_valid, out_tw1, out_tw2, out_tw3, out_tw4
  );

  modport slave (
    input  in_valid, in_mode, in_addr1, in_addr2, in_addr3, in_addr4, out_ready,
    output in_ready, out_valid, out_tw1, out_tw2, out_tw3, out_tw4
  );

endinterface

// File: rtl/twiddle_rom_server_zeta_lane.sv
// One twiddle lane: zeta table read, mode-dependent negation, output register.
// One cycle from addr/mode to tw; holds its value whenever en is low.
module zeta_lane
  import dilithium_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic [ADDR_W-1:0]  addr,
  output logic [COEFF_W-1:0] tw
);

  logic [COEFF_W-1:0] zeta;
  logic [COEFF_W:0]   neg;
  logic [COEFF_W-1:0] tw_d;

  assign zeta = COEFF_W'(ZETA_TABLE[addr]);
  assign neg  = (COEFF_W+1)'(Q) - {1'b0, zeta};

  // Zero must stay zero under negation, otherwise the result would be Q itself.
  always_comb begin
    tw_d = '0;
    case (mode)
      FORWARD_NTT_MODE: tw_d = zeta;
      INVERSE_NTT_MODE: tw_d = (zeta == '0) ? '0 : COEFF_W'(neg);
      default:          tw_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tw <= '0;
    end else if (en) begin
      tw <= tw_d;
    end
  end

endmodule

// File: rtl/twiddle_rom_server.sv
// Serves four zeta values per beat from four addresses; 2-cycle latency, 1 beat/cycle.
// Global stall when out_valid & ~out_ready freezes both stages; flush clears valids.
module twiddle_rom_server
  import dilithium_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  twiddle_rom_server_if.slave bus
);

  logic              stall;
  logic              en;
  logic              in_ready;
  logic              s1_valid;
  logic              s2_valid;
  logic [2:0]        s1_mode;
  logic [ADDR_W-1:0] in_addr [4];
  logic [ADDR_W-1:0] s1_addr [4];
  logic [COEFF_W-1:0] tw_q   [4];

  assign stall    = s2_valid & ~bus.out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;

  assign in_addr[0] = bus.in_addr1;
  assign in_addr[1] = bus.in_addr2;
  assign in_addr[2] = bus.in_addr3;
  assign in_addr[3] = bus.in_addr4;

  // Flush takes priority over stall so a stuck beat can always be discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.in_valid & in_ready;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_mode <= '0;
      for (int i = 0; i < 4; i++) s1_addr[i] <= '0;
    end else if (en) begin
      s1_mode <= bus.in_mode;
      for (int i = 0; i < 4; i++) s1_addr[i] <= in_addr[i];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    zeta_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (s1_mode),
      .addr (s1_addr[g]),
      .tw   (tw_q[g])
    );
  end

  assign bus.out_tw1 = tw_q[0];
  assign bus.out_tw2 = tw_q[1];
  assign bus.out_tw3 = tw_q[2];
  assign bus.out_tw4 = tw_q[3];

endmodule

// File: tb/tb_twiddle_rom_server.sv
// Scoreboard bench: accepted beats push model twiddles; a negedge monitor pops and compares.
module tb_twiddle_rom_server;
  import dilithium_pkg::*;

  typedef logic [3:0][COEFF_W-1:0] tw4_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   delivered = 0;
  tw4_t sb[$];
  logic prev_stall = 1'b0;
  tw4_t prev_tw;

  twiddle_rom_server_if bus();

  twiddle_rom_server dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference rule straight from the table: forward = z, inverse = (Q - z) mod Q, others = 0.
  function automatic logic [COEFF_W-1:0] ref_tw(input logic [2:0] m, input logic [7:0] a);
    int z;
    z = ZETA_TABLE[a];
    if (m == 3'd0) return COEFF_W'(z);
    if (m == 3'd1) return COEFF_W'((Q - z) % Q);
    return '0;
  endfunction

  function automatic tw4_t cur_tw();
    return {bus.out_tw4, bus.out_tw3, bus.out_tw2, bus.out_tw1};
  endfunction

  always @(negedge clk) begin
    tw4_t e;
    tw4_t c;
    c = cur_tw();
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (prev_stall) begin
        chk("stall_hold_valid", bus.out_valid, 1);
        for (int i = 0; i < 4; i++) chk("stall_hold_tw", c[i], prev_tw[i]);
      end
      if (bus.out_valid && bus.out_ready) begin
        delivered++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat got tw1=%0d exp=no beat at %0t", c[0], $time);
        end else begin
          e = sb.pop_front();
          for (int i = 0; i < 4; i++) chk("sb_tw", c[i], e[i]);
        end
      end
      if (flush) begin
        sb.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        e[0] = ref_tw(bus.in_mode, bus.in_addr1);
        e[1] = ref_tw(bus.in_mode, bus.in_addr2);
        e[2] = ref_tw(bus.in_mode, bus.in_addr3);
        e[3] = ref_tw(bus.in_mode, bus.in_addr4);
        sb.push_back(e);
      end
      prev_stall = bus.out_valid && !bus.out_ready && !flush;
      prev_tw = c;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] m, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [7:0] a3, input logic [7:0] a4);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_addr1 = a1;
    bus.in_addr2 = a2;
    bus.in_addr3 = a3;
    bus.in_addr4 = a4;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_tw(input string name, input int e1, input int e2, input int e3, input int e4);
    chk(name, bus.out_tw1, e1);
    chk(name, bus.out_tw2, e2);
    chk(name, bus.out_tw3, e3);
    chk(name, bus.out_tw4, e4);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush = 1'b0;
    while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
      step();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int d0;
    int r;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 3'd0;
    bus.in_addr1  = '0;
    bus.in_addr2  = '0;
    bus.in_addr3  = '0;
    bus.in_addr4  = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("reset_out_valid", bus.out_valid, 0);
    chk_tw("reset_tw", 0, 0, 0, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    step();
    step();
    rst = 1'b0;
    step();

    // Forward, exact 2-cycle latency
    send(3'd0, 8'd1, 8'd2, 8'd3, 8'd0);
    chk("fwd_lat1_valid", bus.out_valid, 0);
    step();
    chk("fwd_lat2_valid", bus.out_valid, 1);
    chk_tw("fwd_tw", 25847, 5771523, 7861508, 0);
    step();

    // Inverse negation, entry 0 stays 0
    send(3'd1, 8'd1, 8'd2, 8'd3, 8'd0);
    step();
    chk("inv_valid", bus.out_valid, 1);
    chk_tw("inv_tw", 8354570, 2608894, 518909, 0);
    step();

    // Passthrough-zero mode
    send(3'd5, 8'd1, 8'd2, 8'd3, 8'd4);
    step();
    chk("other_mode_valid", bus.out_valid, 1);
    chk_tw("other_mode_tw", 0, 0, 0, 0);
    step();

    // Back-pressure: 8 beats with out_ready low on cycles 3-5
    d0 = delivered;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(3'd0, 8'(i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)));
      end
      begin
        for (int c = 0; c < 12; c++) begin
          bus.out_ready = !(c >= 3 && c <= 5);
          step();
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_delivered", delivered - d0, 8);

    // Mode interleave on addr 1, no bubble
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = (i < 6);
      bus.in_mode  = 3'(i % 2);
      bus.in_addr1 = 8'd1;
      bus.in_addr2 = 8'd0;
      bus.in_addr3 = 8'd0;
      bus.in_addr4 = 8'd0;
      step();
      if (i >= 1 && i <= 6) begin
        chk("interleave_valid", bus.out_valid, 1);
        chk("interleave_tw1", bus.out_tw1, ((i - 1) % 2 == 0) ? 25847 : 8354570);
      end
    end
    bus.in_valid = 1'b0;
    drain();

    // Flush during stall with two beats in flight
    bus.out_ready = 1'b0;
    send(3'd0, 8'd4, 8'd5, 8'd6, 8'd7);
    send(3'd1, 8'd8, 8'd9, 8'd10, 8'd11);
    chk("flush_pre_valid", bus.out_valid, 1);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_stall_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush_no_ghost", bus.out_valid, 0);
    end

    // Flush drops a beat offered in the same cycle
    bus.in_valid = 1'b1;
    bus.in_mode  = 3'd0;
    bus.in_addr1 = 8'd2;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_drop_in", bus.out_valid, 0);
    end

    // Async reset mid-stream
    bus.out_ready = 1'b0;
    send(3'd0, 8'd1, 8'd2, 8'd3, 8'd4);
    step();
    chk("rst_pre_valid", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", bus.out_valid, 0);
    chk_tw("rst_async_tw", 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    step();
    bus.out_ready = 1'b1;
    send(3'd1, 8'd3, 8'd2, 8'd1, 8'd0);
    chk("post_rst_lat1", bus.out_valid, 0);
    step();
    chk("post_rst_lat2", bus.out_valid, 1);
    chk_tw("post_rst_tw", 518909, 2608894, 8354570, 0);
    step();

    // Randomized traffic with back-pressure and occasional flush
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_mode   = (r < 4) ? 3'd0 : (r < 8) ? 3'd1 : 3'($urandom_range(2, 7));
      bus.in_addr1  = 8'($urandom_range(0, 255));
      bus.in_addr2  = 8'($urandom_range(0, 255));
      bus.in_addr3  = 8'($urandom_range(0, 255));
      bus.in_addr4  = 8'($urandom_range(0, 255));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 59) == 0);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
